counter_32_checker: RTL

Passive, synthesizable checker for the 32-bit up/down/load counter. It observes the counter's control inputs (mode, load, data) and its registered output on the same clock. It predicts the next count, compares every cycle, counts mismatches and wrap events, and captures the first failure for debug. It sits beside the counter in the verification/FPGA test harness and never drives the counter.

---
 rtl/counter_32_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/counter_32_checker.sv
// counter_32_checker: passive scoreboard for a 32-bit up/down/load counter.
// Predicts the counter's next value from the observed controls and the
// observed output, compares every cycle, and keeps saturating statistics
// (mismatch count, wrap counts) plus a capture of the first mismatch.
module counter_32_checker #(
  parameter int ERR_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             mode,
  input  logic             load,
  input  logic [31:0]      data,
  input  logic [31:0]      data_out,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             first_valid,
  output logic [31:0]      first_exp,
  output logic [31:0]      first_act,
  output logic [ERR_W-1:0] wrap_up_count,
  output logic [ERR_W-1:0] wrap_dn_count,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      exp_q, exp_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             first_valid_q, first_valid_d;
  logic [31:0]      first_exp_q, first_exp_d;
  logic [31:0]      first_act_q, first_act_d;
  logic [ERR_W-1:0] wrap_up_q, wrap_up_d;
  logic [ERR_W-1:0] wrap_dn_q, wrap_dn_d;

  logic [31:0]      pred;
  logic             mism;
  logic             wrap_up_hit;
  logic             wrap_dn_hit;

  // Counters stick at all-ones rather than rolling over.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-value prediction, always rebuilt from the observed output so a single
  // bad cycle yields a single error instead of a cascade.
  always_comb begin
    pred = '0;
    if (load)
      pred = data;
    else if (mode)
      pred = data_out + 32'd1;
    else
      pred = data_out - 32'd1;
    mism        = (data_out != exp_q);
    wrap_up_hit = !load &&  mode && (data_out == 32'hFFFF_FFFF);
    wrap_dn_hit = !load && !mode && (data_out == 32'h0000_0000);
  end

  // Next-state, comparison and statistics; clear outranks everything.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    err_d         = 1'b0;
    err_count_d   = err_count_q;
    first_valid_d = first_valid_q;
    first_exp_d   = first_exp_q;
    first_act_d   = first_act_q;
    wrap_up_d     = wrap_up_q;
    wrap_dn_d     = wrap_dn_q;

    if (clear) begin
      err_count_d   = '0;
      first_valid_d = 1'b0;
      first_exp_d   = '0;
      first_act_d   = '0;
      wrap_up_d     = '0;
      wrap_dn_d     = '0;
      state_d       = enable ? SYNC : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = SYNC;
        end
        SYNC: begin
          if (!enable) begin
            state_d = IDLE;
          end else begin
            exp_d   = pred;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!enable) begin
            state_d = IDLE;
          end else begin
            if (mism) begin
              err_d       = 1'b1;
              err_count_d = sat_inc(err_count_q);
              if (!first_valid_q) begin
                first_valid_d = 1'b1;
                first_exp_d   = exp_q;
                first_act_d   = data_out;
              end
            end
            if (wrap_up_hit) wrap_up_d = sat_inc(wrap_up_q);
            if (wrap_dn_hit) wrap_dn_d = sat_inc(wrap_dn_q);
            exp_d   = pred;
            state_d = (STOP_ON_ERR && mism) ? HALT : CHECK;
          end
        end
        HALT: begin
          // Frozen until clear or rst; enable is ignored here.
          state_d = HALT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and statistics registers, cleared asynchronously with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      exp_q         <= '0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
      first_valid_q <= 1'b0;
      first_exp_q   <= '0;
      first_act_q   <= '0;
      wrap_up_q     <= '0;
      wrap_dn_q     <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
      first_valid_q <= first_valid_d;
      first_exp_q   <= first_exp_d;
      first_act_q   <= first_act_d;
      wrap_up_q     <= wrap_up_d;
      wrap_dn_q     <= wrap_dn_d;
    end
  end

  assign err           = err_q;
  assign err_count     = err_count_q;
  assign first_valid   = first_valid_q;
  assign first_exp     = first_exp_q;
  assign first_act     = first_act_q;
  assign wrap_up_count = wrap_up_q;
  assign wrap_dn_count = wrap_dn_q;
  assign halted        = (state_q == HALT);

endmodule
